// File: rtl/result_rx.sv
// Serial-to-parallel receiver for the motion-estimation result link.
// Rebuilds SAD and x/y motion-vector words from three MSB-first serial lines.
module result_rx #(
    parameter int SAD_W     = 14,
    parameter int MV_W      = 4,
    parameter int START_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             sad_in,
    input  logic             x_in,
    input  logic             y_in,
    output logic [SAD_W-1:0] sad_out,
    output logic [MV_W-1:0]  x_out,
    output logic [MV_W-1:0]  y_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int BIT_W  = (SAD_W > 1) ? $clog2(SAD_W) : 1;
    localparam int LEAD_W = (START_DLY > 2) ? $clog2(START_DLY - 1) : 1;
    localparam logic [LEAD_W-1:0] LEAD_INIT = LEAD_W'((START_DLY >= 2) ? START_DLY - 2 : 0);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SAD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [LEAD_W-1:0]  lead_cnt_q, lead_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SAD_W-1:0]   sad_sr_q, sad_sr_d;
    logic [MV_W-1:0]    x_sr_q, x_sr_d;
    logic [MV_W-1:0]    y_sr_q, y_sr_d;
    logic [SAD_W-1:0]   sad_out_q, sad_out_d;
    logic [MV_W-1:0]    x_out_q, x_out_d;
    logic [MV_W-1:0]    y_out_q, y_out_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        lead_cnt_d  = lead_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sad_sr_d    = sad_sr_q;
        x_sr_d      = x_sr_q;
        y_sr_d      = y_sr_q;
        sad_out_d   = sad_out_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;

        // A strobe always restarts framing; outside IDLE it also discards the frame in flight.
        if (frame_start) begin
            frame_err_d = (state_q != IDLE);
            state_d     = (START_DLY == 1) ? SHIFT : LEAD;
            lead_cnt_d  = LEAD_INIT;
            bit_cnt_d   = '0;
        end else begin
            case (state_q)
                LEAD: begin
                    if (lead_cnt_q == '0) begin
                        state_d = SHIFT;
                    end else begin
                        lead_cnt_d = lead_cnt_q - LEAD_W'(1);
                    end
                end
                SHIFT: begin
                    sad_sr_d  = {sad_sr_q[SAD_W-2:0], sad_in};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (int'(bit_cnt_q) < MV_W) begin
                        x_sr_d = (x_sr_q << 1) | MV_W'(x_in);
                        y_sr_d = (y_sr_q << 1) | MV_W'(y_in);
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        sad_out_d   = {sad_sr_q[SAD_W-2:0], sad_in};
                        x_out_d     = x_sr_q;
                        y_out_d     = y_sr_q;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lead_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sad_sr_q    <= '0;
            x_sr_q      <= '0;
            y_sr_q      <= '0;
            sad_out_q   <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lead_cnt_q  <= lead_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sad_sr_q    <= sad_sr_d;
            x_sr_q      <= x_sr_d;
            y_sr_q      <= y_sr_d;
            sad_out_q   <= sad_out_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign sad_out   = sad_out_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_result_rx.sv
// Bench for result_rx: three instances (START_DLY 2, 1, 4) share the serial lines,
// each has its own frame_start; a monitor pops expected results as outputs appear.
module tb_result_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  fs = '0;
    logic        sad_in = 1'b0;
    logic        x_in = 1'b0;
    logic        y_in = 1'b0;
    logic [13:0] sad_o [3];
    logic [3:0]  x_o [3];
    logic [3:0]  y_o [3];
    logic [2:0]  valid_o;
    logic [2:0]  busy_o;
    logic [2:0]  err_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // {sel[1:0], cycle[31:0], sad[13:0], x[3:0], y[3:0]}
    logic [55:0] exp_q[$];
    // {sel[1:0], cycle[31:0]}
    logic [33:0] err_q[$];
    int          busy_q[$];
    logic [21:0] hold_v [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    result_rx #(.SAD_W(14), .MV_W(4), .START_DLY(2)) u_d2 (
        .clk(clk), .rst(rst), .frame_start(fs[0]), .sad_in(sad_in), .x_in(x_in), .y_in(y_in),
        .sad_out(sad_o[0]), .x_out(x_o[0]), .y_out(y_o[0]),
        .out_valid(valid_o[0]), .busy(busy_o[0]), .frame_err(err_o[0]));

    result_rx #(.SAD_W(14), .MV_W(4), .START_DLY(1)) u_d1 (
        .clk(clk), .rst(rst), .frame_start(fs[1]), .sad_in(sad_in), .x_in(x_in), .y_in(y_in),
        .sad_out(sad_o[1]), .x_out(x_o[1]), .y_out(y_o[1]),
        .out_valid(valid_o[1]), .busy(busy_o[1]), .frame_err(err_o[1]));

    result_rx #(.SAD_W(14), .MV_W(4), .START_DLY(4)) u_d4 (
        .clk(clk), .rst(rst), .frame_start(fs[2]), .sad_in(sad_in), .x_in(x_in), .y_in(y_in),
        .sad_out(sad_o[2]), .x_out(x_o[2]), .y_out(y_o[2]),
        .out_valid(valid_o[2]), .busy(busy_o[2]), .frame_err(err_o[2]));

    function automatic int dly(input int s);
        return (s == 0) ? 2 : (s == 1) ? 1 : 4;
    endfunction

    // Strobe instance s, then clock out one frame MSB first. steps=0 runs the whole
    // frame and expects a result; steps>0 stops early (frame abandoned).
    task automatic send_frame(input int s, input logic [13:0] sad, input logic [3:0] x,
                              input logic [3:0] y, input int steps, input bit exp_err);
        int d;
        int k;
        int last;
        int i;
        logic [1:0] sel;
        d    = dly(s);
        sel  = 2'(s);
        last = (steps == 0) ? d + 13 : steps;
        @(negedge clk);
        k = cyc + 1;
        fs = '0;
        fs[s] = 1'b1;
        sad_in = 1'($urandom_range(0, 1));
        x_in   = 1'($urandom_range(0, 1));
        y_in   = 1'($urandom_range(0, 1));
        if (exp_err) err_q.push_back({sel, 32'(k)});
        if (steps == 0) exp_q.push_back({sel, 32'(k + d + 13), sad, x, y});
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            fs = '0;
            sad_in = 1'($urandom_range(0, 1));
            x_in   = 1'($urandom_range(0, 1));
            y_in   = 1'($urandom_range(0, 1));
            if (j >= d) begin
                i = j - d;
                sad_in = sad[13 - i];
                if (i < 4) begin
                    x_in = x[3 - i];
                    y_in = y[3 - i];
                end
            end
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [55:0] e;
        logic [33:0] ee;
        int run;
        run = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 3; s++) begin
                if (rst) begin
                    tests++;
                    hold_v[s] = '0;
                    if ({sad_o[s], x_o[s], y_o[s]} != 22'd0 || valid_o[s] || busy_o[s] || err_o[s]) begin
                        fails++;
                        $display("FAIL reset_state dut%0d cyc=%0d got sad=%h x=%h y=%h v=%b b=%b e=%b want all 0",
                                 s, cyc, sad_o[s], x_o[s], y_o[s], valid_o[s], busy_o[s], err_o[s]);
                    end
                    continue;
                end
                tests++;
                if (valid_o[s]) begin
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_valid dut%0d cyc=%0d got sad=%h x=%h y=%h want no valid",
                                 s, cyc, sad_o[s], x_o[s], y_o[s]);
                    end else begin
                        e = exp_q.pop_front();
                        hold_v[s] = e[21:0];
                        if (int'(e[55:54]) != s || e[53:22] != 32'(cyc) || {sad_o[s], x_o[s], y_o[s]} != e[21:0]) begin
                            fails++;
                            $display("FAIL result dut%0d got cyc=%0d sad=%h x=%h y=%h want dut%0d cyc=%0d sad=%h x=%h y=%h",
                                     s, cyc, sad_o[s], x_o[s], y_o[s], e[55:54], e[53:22], e[21:8], e[7:4], e[3:0]);
                        end
                    end
                end else if ({sad_o[s], x_o[s], y_o[s]} != hold_v[s]) begin
                    fails++;
                    $display("FAIL hold dut%0d cyc=%0d got %h want %h", s, cyc,
                             {sad_o[s], x_o[s], y_o[s]}, hold_v[s]);
                end
                if (err_o[s]) begin
                    tests++;
                    if (err_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_err dut%0d cyc=%0d got frame_err=1 want 0", s, cyc);
                    end else begin
                        ee = err_q.pop_front();
                        if (int'(ee[33:32]) != s || ee[31:0] != 32'(cyc)) begin
                            fails++;
                            $display("FAIL frame_err dut%0d got cyc=%0d want dut%0d cyc=%0d",
                                     s, cyc, ee[33:32], ee[31:0]);
                        end
                    end
                end
            end
            if (!rst && busy_o[0]) begin
                run++;
            end else begin
                if (run > 0 && busy_q.size() > 0) begin
                    int want;
                    want = busy_q.pop_front();
                    tests++;
                    if (run != want) begin
                        fails++;
                        $display("FAIL busy_len dut0 got %0d cycles want %0d", run, want);
                    end
                end
                run = 0;
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single frame, then a back-to-back frame strobed in the out_valid cycle.
        busy_q.push_back(15);
        send_frame(0, 14'h2A5B, 4'hA, 4'h3, 0, 1'b0);
        send_frame(0, 14'h3FFF, 4'hF, 4'h0, 0, 1'b0);
        repeat (3) @(negedge clk);

        // Abort: second strobe 7 edges into the first frame.
        send_frame(0, 14'h1111, 4'h1, 4'h2, 6, 1'b0);
        send_frame(0, 14'h0ABC, 4'h7, 4'h8, 0, 1'b1);
        repeat (2) @(negedge clk);

        // Reset lands on the SHIFT edge that would sample bit 5.
        send_frame(0, 14'h2222, 4'h3, 4'h4, 6, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_frame(0, 14'h1357, 4'h2, 4'hD, 0, 1'b0);
        repeat (2) @(negedge clk);

        // x/y lines toggle randomly after their last sample.
        send_frame(0, 14'h0001, 4'h5, 4'h9, 0, 1'b0);
        repeat (2) @(negedge clk);

        // START_DLY sweep.
        send_frame(1, 14'h1234, 4'hC, 4'h6, 0, 1'b0);
        send_frame(1, 14'h0F0F, 4'h9, 4'h1, 0, 1'b0);
        repeat (2) @(negedge clk);
        send_frame(2, 14'h1234, 4'hC, 4'h6, 0, 1'b0);
        send_frame(2, 14'h2C3D, 4'h4, 4'hB, 0, 1'b0);

        t = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0 || err_q.size() != 0 || busy_q.size() != 0) begin
            fails++;
            $display("FAIL drain got pending results=%0d errs=%0d busy=%0d want 0 0 0",
                     exp_q.size(), err_q.size(), busy_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
